// File: rtl/log2_sweep_sequencer_pkg.sv
// Shared types and defaults for the log2 sweep sequencer and its watchdog.
package log2_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int TIMEOUT_DEF = 40;

  localparam logic [7:0] ERR_K = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    HOLD,
    FINISH
  } state_t;

endpackage

// File: rtl/log2_sweep_sequencer_watchdog.sv
// Loadable down-counter: clear reloads, enable counts toward zero, expired at zero.
module c6_watchdog #(
  parameter int CW   = 6,
  parameter int LOAD = 39
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= CW'(LOAD);
    end else if (i_clear) begin
      r_cnt <= CW'(LOAD);
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/log2_sweep_sequencer.sv
// Sweeps N over [first_n, last_n], runs the log2 engine once per N and hands
// each (N, k) result downstream over valid/ready, with a per-operand watchdog.
module log2_sweep_sequencer
  import log2_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_go,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_first_n,
  input  logic [WIDTH-1:0] i_last_n,
  output logic [WIDTH-1:0] o_dp_n_input,
  output logic             o_dp_start,
  output logic             o_dp_reset,
  input  logic [WIDTH-1:0] i_dp_result,
  input  logic             i_dp_done,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_n,
  output logic [WIDTH-1:0] o_out_k,
  output logic             o_out_err,
  output logic             o_busy,
  output logic             o_sweep_done,
  output logic             o_cfg_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_n;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] r_out_n;
  logic [WIDTH-1:0] r_out_k;
  logic             r_out_err;
  logic             r_sweep_done;
  logic             r_cfg_err;

  logic w_go_ok;
  logic w_abort;
  logic w_xfer;
  logic w_at_last;
  logic w_expired;
  logic w_wd_clear;
  logic w_wd_run;
  logic w_dp_reset;
  logic w_dp_start;

  assign w_go_ok    = i_go && (i_first_n != '0) && (i_first_n <= i_last_n);
  assign w_abort    = i_abort && (r_state != IDLE);
  assign w_xfer     = (r_state == HOLD) && i_out_ready;
  // Equality on the widened counter, tested before incrementing, so last_n = max never wraps.
  assign w_at_last  = (r_n == {1'b0, r_last});
  assign w_wd_clear = (r_state == CLEAR);
  assign w_wd_run   = (r_state == RUN);

  c6_watchdog #(
    .CW   (WD_W),
    .LOAD (TIMEOUT - 1)
  ) u_watchdog (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_run),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next     = r_state;
    w_dp_reset = 1'b1;
    w_dp_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_go) w_next = w_go_ok ? CLEAR : FINISH;
      end
      CLEAR: begin
        w_dp_start = 1'b1;
        w_next     = RUN;
      end
      RUN: begin
        w_dp_reset = 1'b0;
        w_dp_start = 1'b1;
        if (i_dp_done || w_expired) w_next = HOLD;
      end
      HOLD: begin
        if (w_xfer) w_next = w_at_last ? FINISH : CLEAR;
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_n          <= '0;
      r_last       <= '0;
      r_out_n      <= '0;
      r_out_k      <= '0;
      r_out_err    <= 1'b0;
      r_sweep_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_sweep_done <= (r_state == FINISH) && !i_abort;
      r_cfg_err    <= (r_state == IDLE) && i_go && !w_go_ok;
      case (r_state)
        IDLE: begin
          if (w_go_ok) begin
            r_n    <= {1'b0, i_first_n};
            r_last <= i_last_n;
          end
        end
        RUN: begin
          // Result bus is only meaningful while done is high; done wins a tie with the watchdog.
          if (i_dp_done) begin
            r_out_k   <= i_dp_result;
            r_out_n   <= r_n[WIDTH-1:0];
            r_out_err <= 1'b0;
          end else if (w_expired) begin
            r_out_k   <= WIDTH'(ERR_K);
            r_out_n   <= r_n[WIDTH-1:0];
            r_out_err <= 1'b1;
          end
        end
        HOLD: begin
          if (w_xfer && !w_at_last) r_n <= r_n + 1'b1;
        end
        default: ;
      endcase
      if (w_abort) begin
        r_n    <= '0;
        r_last <= '0;
      end
    end
  end

  assign o_dp_n_input = r_n[WIDTH-1:0];
  assign o_dp_start   = w_dp_start;
  assign o_dp_reset   = w_dp_reset;
  assign o_out_valid  = (r_state == HOLD);
  assign o_out_n      = r_out_n;
  assign o_out_k      = r_out_k;
  assign o_out_err    = r_out_err;
  assign o_busy       = (r_state != IDLE);
  assign o_sweep_done = r_sweep_done;
  assign o_cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_log2_sweep_sequencer.sv
// Directed bench for log2_sweep_sequencer with a behavioural engine stub.
module tb_log2_sweep_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] first_n = 8'd0;
  logic [7:0] last_n = 8'd0;
  logic [7:0] dp_n;
  logic       dp_start;
  logic       dp_reset;
  logic [7:0] dp_result;
  logic       dp_done;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_n;
  logic [7:0] out_k;
  logic       out_err;
  logic       busy;
  logic       sweep_done;
  logic       cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  log2_sweep_sequencer #(.WIDTH(8), .TIMEOUT(40)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_go         (go),
    .i_abort      (abort),
    .i_first_n    (first_n),
    .i_last_n     (last_n),
    .o_dp_n_input (dp_n),
    .o_dp_start   (dp_start),
    .o_dp_reset   (dp_reset),
    .i_dp_result  (dp_result),
    .i_dp_done    (dp_done),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_n      (out_n),
    .o_out_k      (out_k),
    .o_out_err    (out_err),
    .o_busy       (busy),
    .o_sweep_done (sweep_done),
    .o_cfg_err    (cfg_err)
  );

  function automatic int flog2(input int v);
    int r = 0;
    while (v > 1) begin
      v = v >> 1;
      r++;
    end
    return r;
  endfunction

  // Engine stub: latency 2+2*floor(log2 N) after reset release; junk on result until done.
  logic stuck = 1'b0;
  int   eng_cnt = 0;
  logic eng_done = 1'b0;

  always @(posedge clk) begin
    if (dp_reset) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else if (!stuck && !eng_done) begin
      if (eng_cnt >= 1 + 2 * flog2(int'(dp_n))) eng_done <= 1'b1;
      else eng_cnt <= eng_cnt + 1;
    end
  end

  assign dp_done   = eng_done;
  assign dp_result = eng_done ? 8'(flog2(int'(dp_n))) : 8'hEE;

  typedef struct packed {
    logic [7:0] n;
    logic [7:0] k;
    logic       err;
  } res_t;

  res_t q[$];
  int   sd_cnt = 0;
  int   cfg_cnt = 0;
  int   valid_cnt = 0;
  int   run_cyc = 0;
  int   stall_breaks = 0;
  int   sd_base = 0;
  logic prev_stall = 1'b0;
  res_t prev_res;

  // Inputs change just after posedge, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) q.push_back('{n: out_n, k: out_k, err: out_err});
      if (sweep_done) sd_cnt++;
      if (cfg_err) cfg_cnt++;
      if (out_valid) valid_cnt++;
      if (!dp_reset) run_cyc++;
      if (prev_stall && out_valid && (prev_res != {out_n, out_k, out_err})) stall_breaks++;
      prev_stall = out_valid && !out_ready;
      prev_res   = '{n: out_n, k: out_k, err: out_err};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_go(input logic [7:0] f, input logic [7:0] l);
    sd_base = sd_cnt;
    first_n = f;
    last_n  = l;
    go      = 1'b1;
    tick();
    go      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sd_cnt > sd_base) begin
        ok = 1'b1;
        break;
      end
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({dp_reset, dp_start, dp_n} !== {1'b1, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_dp got reset=%0b start=%0b n=%0d want 1 0 0", dp_reset, dp_start, dp_n);
    end
    n_cmp++;
    if ({out_valid, out_n, out_k, out_err} !== {1'b0, 8'd0, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_out got v=%0b n=%0d k=%0d e=%0b want 0 0 0 0", out_valid, out_n, out_k, out_err);
    end
    n_cmp++;
    if ({busy, sweep_done, cfg_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_status got busy=%0b sd=%0b cfg=%0b want 000", busy, sweep_done, cfg_err);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_busy got %0b want 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] en[4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [7:0] ek[4] = '{8'd0, 8'd1, 8'd1, 8'd2};
    bit ok;
    q.delete();
    out_ready = 1'b1;
    start_go(8'd1, 8'd4);
    n_cmp++;
    if ({dp_reset, dp_start, busy} !== 3'b111) begin
      n_bad++;
      $display("FAIL basic_clear got reset=%0b start=%0b busy=%0b want 111", dp_reset, dp_start, busy);
    end
    tick();
    n_cmp++;
    if ({dp_reset, dp_start, dp_n} !== {1'b0, 1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL basic_run got reset=%0b start=%0b n=%0d want 0 1 1", dp_reset, dp_start, dp_n);
    end
    wait_done(300, 1'b0, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL basic_timeout got no sweep_done want sweep_done within 300 cycles");
    end
    n_cmp++;
    if (q.size() != 4) begin
      n_bad++;
      $display("FAIL basic_count got %0d want 4", q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (q[i] !== '{n: en[i], k: ek[i], err: 1'b0}) begin
          n_bad++;
          $display("FAIL basic_res[%0d] got (%0d,%0d,%0b) want (%0d,%0d,0)", i, q[i].n, q[i].k, q[i].err, en[i], ek[i]);
        end
      end
    end
    repeat (3) tick();
    n_cmp++;
    if ((sd_cnt - sd_base) != 1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_end got sweep_done=%0d busy=%0b valid=%0b want 1 0 0", sd_cnt - sd_base, busy, out_valid);
    end
  endtask

  task automatic test_stall();
    bit ok = 1'b0;
    q.delete();
    out_ready = 1'b0;
    start_go(8'd6, 8'd6);
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!ok || out_n !== 8'd6 || out_k !== 8'd2 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_first got valid=%0b (%0d,%0d,%0b) want 1 (6,2,0)", out_valid, out_n, out_k, out_err);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, out_n, out_k, dp_reset} !== {1'b1, 8'd6, 8'd2, 1'b1}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d] got v=%0b n=%0d k=%0d rst=%0b want 1 6 2 1", i, out_valid, out_n, out_k, dp_reset);
      end
    end
    out_ready = 1'b1;
    wait_done(50, 1'b0, ok);
    n_cmp++;
    if (!ok || q.size() != 1) begin
      n_bad++;
      $display("FAIL stall_release got done=%0b results=%0d want 1 1", ok, q.size());
    end
  endtask

  task automatic test_long();
    bit ok;
    q.delete();
    start_go(8'd1, 8'd128);
    wait_done(30000, 1'b1, ok);
    n_cmp++;
    if (!ok || q.size() != 128) begin
      n_bad++;
      $display("FAIL long_count got done=%0b results=%0d want 1 128", ok, q.size());
    end else begin
      for (int i = 0; i < 128; i++) begin
        n_cmp++;
        if (q[i] !== '{n: 8'(i + 1), k: 8'(flog2(i + 1)), err: 1'b0}) begin
          n_bad++;
          $display("FAIL long_res[%0d] got (%0d,%0d,%0b) want (%0d,%0d,0)", i, q[i].n, q[i].k, q[i].err, i + 1, flog2(i + 1));
        end
      end
      n_cmp++;
      if (q[127] !== '{n: 8'd128, k: 8'd7, err: 1'b0}) begin
        n_bad++;
        $display("FAIL long_last got (%0d,%0d,%0b) want (128,7,0)", q[127].n, q[127].k, q[127].err);
      end
    end
    n_cmp++;
    if (stall_breaks != 0) begin
      n_bad++;
      $display("FAIL long_stall_stable got %0d changes want 0", stall_breaks);
    end
  endtask

  task automatic test_cfg_err();
    logic [7:0] fv[2] = '{8'd5, 8'd0};
    int v0;
    for (int c = 0; c < 2; c++) begin
      q.delete();
      v0 = valid_cnt;
      start_go(fv[c], 8'd3);
      n_cmp++;
      if ({cfg_err, sweep_done, busy} !== 3'b101) begin
        n_bad++;
        $display("FAIL cfg_pulse[%0d] got cfg=%0b sd=%0b busy=%0b want 101", c, cfg_err, sweep_done, busy);
      end
      tick();
      n_cmp++;
      if ({cfg_err, sweep_done, busy} !== 3'b010) begin
        n_bad++;
        $display("FAIL cfg_done[%0d] got cfg=%0b sd=%0b busy=%0b want 010", c, cfg_err, sweep_done, busy);
      end
      tick();
      n_cmp++;
      if (valid_cnt != v0 || q.size() != 0) begin
        n_bad++;
        $display("FAIL cfg_noresult[%0d] got valid_cycles=%0d results=%0d want 0 0", c, valid_cnt - v0, q.size());
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int r0;
    q.delete();
    stuck = 1'b1;
    out_ready = 1'b1;
    r0 = run_cyc;
    start_go(8'd250, 8'd255);
    wait_done(2000, 1'b0, ok);
    n_cmp++;
    if (!ok || q.size() != 6) begin
      n_bad++;
      $display("FAIL wd_count got done=%0b results=%0d want 1 6", ok, q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (q[i] !== '{n: 8'(250 + i), k: 8'hFF, err: 1'b1}) begin
          n_bad++;
          $display("FAIL wd_res[%0d] got (%0d,%0h,%0b) want (%0d,ff,1)", i, q[i].n, q[i].k, q[i].err, 250 + i);
        end
      end
    end
    n_cmp++;
    if (run_cyc - r0 != 240) begin
      n_bad++;
      $display("FAIL wd_run_cycles got %0d want 240", run_cyc - r0);
    end
    repeat (3) tick();
    n_cmp++;
    if ((sd_cnt - sd_base) != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_end got sweep_done=%0d busy=%0b want 1 0", sd_cnt - sd_base, busy);
    end
    stuck = 1'b0;
  endtask

  task automatic test_abort();
    bit ok = 1'b0;
    q.delete();
    out_ready = 1'b1;
    start_go(8'd90, 8'd110);
    for (int i = 0; i < 3000; i++) begin
      if (dp_n == 8'd100 && dp_reset == 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL abort_reach got no RUN at N=100 want RUN at N=100");
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({busy, out_valid, dp_reset, dp_start} !== 4'b0010) begin
      n_bad++;
      $display("FAIL abort_idle got busy=%0b v=%0b rst=%0b start=%0b want 0010", busy, out_valid, dp_reset, dp_start);
    end
    repeat (5) tick();
    n_cmp++;
    if (sd_cnt != sd_base || q.size() != 10) begin
      n_bad++;
      $display("FAIL abort_nodone got sweep_done=%0d results=%0d want 0 10", sd_cnt - sd_base, q.size());
    end
    q.delete();
    start_go(8'd3, 8'd3);
    wait_done(100, 1'b0, ok);
    n_cmp++;
    if (!ok || q.size() != 1 || q[0] !== '{n: 8'd3, k: 8'd1, err: 1'b0}) begin
      n_bad++;
      $display("FAIL abort_restart got done=%0b results=%0d want 1 1 with (3,1,0)", ok, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_long();
    test_cfg_err();
    test_timeout();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
